uart_receiver: RTL and testbench

//  UART receive path. Consumes the 16x-oversampling sample_ENABLE tick from the baud rate controller and

---
 rtl/uart_receiver.sv | 170 +++++++++++++++++
 tb/tb_uart_receiver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, 16x-oversampled start/data/parity/stop
// deserialiser with registered one-clock valid / parity-error / framing-error strobes.
// Optional build macro: UART_RX_MAJORITY_EN -- each bit decision is the 2-of-3 vote of
// rxd_s at ticks S-2, S-1 and S instead of the single sample at tick S.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_ENABLE,
  input  logic                 Rx_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          tick_reg, tick_next;
  logic [BW-1:0]          bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   perr_reg, perr_next;
  logic [DATA_BITS-1:0]   data_next;
  logic                   valid_next, perr_out_next, ferr_next;
  logic                   rxd_meta, rxd_s;
  logic                   sample_bit;

  // Two-flop synchroniser for the asynchronous serial line (idles high)
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_reg;

  // Keep the two previous tick samples so the decision at tick S can vote over S-2..S
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg <= 2'b11;
    end else if (sample_ENABLE) begin
      hist_reg <= {hist_reg[0], rxd_s};
    end
  end

  assign sample_bit = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rxd_s) | (hist_reg[0] & rxd_s);
`else
  assign sample_bit = rxd_s;
`endif

  // State, counters, shift register and registered output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      perr_reg  <= 1'b0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      perr_reg  <= perr_next;
      Rx_DATA   <= data_next;
      Rx_VALID  <= valid_next;
      Rx_PERROR <= perr_out_next;
      Rx_FERROR <= ferr_next;
    end
  end

  // Next-state logic: frame sequencing advances only on oversampling ticks
  always_comb begin
    state_next    = state_reg;
    tick_next     = tick_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    perr_next     = perr_reg;
    data_next     = Rx_DATA;
    valid_next    = 1'b0;
    perr_out_next = 1'b0;
    ferr_next     = 1'b0;
    if (!Rx_EN) begin
      // Disabled receiver abandons any partial frame; Rx_DATA keeps its last value
      state_next = IDLE;
      tick_next  = '0;
      bit_next   = '0;
    end else if (sample_ENABLE) begin
      case (state_reg)
        IDLE: begin
          if (!rxd_s) begin
            state_next = START;
            tick_next  = '0;
          end
        end
        START: begin
          if (tick_reg == TICK_MID) begin
            tick_next = '0;
            if (sample_bit) begin
              state_next = IDLE;  // start bit did not survive to mid-bit: glitch
            end else begin
              state_next = DATA;
              bit_next   = '0;
              perr_next  = 1'b0;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
        DATA: begin
          tick_next = tick_reg + 1'b1;
          if (tick_reg == TICK_END) begin
            shift_next = {sample_bit, shift_reg[DATA_BITS-1:1]};
            bit_next   = bit_reg + 1'b1;
            if (bit_reg == BIT_LAST) begin
              bit_next   = '0;
              state_next = (PARITY != 0) ? PAR : STOP;
            end
          end
        end
        PAR: begin
          tick_next = tick_reg + 1'b1;
          if (tick_reg == TICK_END) begin
            perr_next  = ^{shift_reg, sample_bit};  // even parity: total ones must be even
            state_next = STOP;
          end
        end
        STOP: begin
          tick_next = tick_reg + 1'b1;
          if (tick_reg == TICK_END) begin
            // Returning to IDLE at mid-stop lets a back-to-back start edge be caught
            data_next     = shift_reg;
            ferr_next     = ~sample_bit;
            perr_out_next = (PARITY != 0) ? perr_reg : 1'b0;
            valid_next    = sample_bit & ~((PARITY != 0) ? perr_reg : 1'b0);
            state_next    = IDLE;
            tick_next     = '0;
          end
        end
        default: begin
          state_next = IDLE;
          tick_next  = '0;
          bit_next   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver (8 data bits, even parity, 16x oversampling):
// the stimulus side pushes the expected frame result computed from the frame contents,
// a monitor pops and compares on every strobe.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_ENABLE = 1'b0;
  logic       Rx_EN = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   period = 1;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1)) dut (
    .clk(clk), .reset(reset), .sample_ENABLE(sample_ENABLE), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  always #5 clk = ~clk;

  // Oversampling tick source: one-clock pulse every 'period' clocks
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt >= period - 1) begin
        cnt = 0;
        sample_ENABLE = 1'b1;
      end else begin
        cnt++;
        sample_ENABLE = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected frames pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (sample_ENABLE !== 1'b1);
    end
    #2;
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    wait_ticks(OS);
  endtask

  // Reference: even parity means the data ones plus the parity bit must sum to an even count
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    exp_t e;
    logic par_bit;
    logic stop_bit;
    par_bit  = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
    if (bad_par) par_bit = ~par_bit;
    stop_bit = ~bad_stop;
    e.data  = d;
    e.perr  = (($countones(d) + int'(par_bit)) % 2) != 0;
    e.ferr  = (stop_bit == 1'b0);
    e.valid = !e.perr && !e.ferr;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par_bit);
    send_bit(stop_bit);
    RxD = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
  endtask

  // Monitor: every strobe consumes one expected frame result
  always @(negedge clk) begin
    if (Rx_VALID || Rx_PERROR || Rx_FERROR) begin
      $display("rx frame data=%02h valid=%0b perr=%0b ferr=%0b", Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got valid=%0b perr=%0b ferr=%0b expected no strobe",
                 Rx_VALID, Rx_PERROR, Rx_FERROR);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", 32'(Rx_DATA), 32'(mon_e.data));
        check("rx_valid", 32'(Rx_VALID), 32'(mon_e.valid));
        check("rx_perror", 32'(Rx_PERROR), 32'(mon_e.perr));
        check("rx_ferror", 32'(Rx_FERROR), 32'(mon_e.ferr));
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic bp, bs;
    reset = 1'b1;
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("reset_data", 32'(Rx_DATA), 32'h0);
    check("reset_strobes", 32'({Rx_VALID, Rx_PERROR, Rx_FERROR}), 32'h0);
    reset = 1'b0;
    Rx_EN = 1'b1;
    wait_ticks(20);

    // Good frame, parity error, framing error
    send_frame(8'hA5, 1'b0, 1'b0);
    wait_ticks(4);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_ticks(4);
    send_frame(8'h81, 1'b0, 1'b1);
    wait_ticks(OS);

    // Short low glitch is rejected, then a normal frame
    RxD = 1'b0;
    wait_ticks(4);
    RxD = 1'b1;
    wait_ticks(40);
    send_frame(8'h55, 1'b0, 1'b0);
    wait_ticks(8);

    // Receiver disabled mid-frame: no strobe, data held
    send_partial(8'hF0, 4);
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    wait_ticks(20);
    check("data_held_after_disable", 32'(Rx_DATA), 32'h55);
    Rx_EN = 1'b1;
    wait_ticks(20);
    send_frame(8'h0F, 1'b0, 1'b0);
    wait_ticks(8);

    // Reset pulsed mid-frame: partial frame discarded, data cleared
    send_partial(8'hF0, 4);
    reset = 1'b1;
    RxD   = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    wait_ticks(20);
    check("data_after_midframe_reset", 32'(Rx_DATA), 32'h0);
    send_frame(8'h0F, 1'b0, 1'b0);
    wait_ticks(8);

    // Back-to-back frames with no idle gap at two tick rates
    period = 1;
    wait_ticks(4);
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0);
    wait_ticks(8);
    period = 54;
    wait_ticks(4);
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b0);
    wait_ticks(8);

    // Randomized frames, tick rates and gaps
    for (int n = 0; n < 30; n++) begin
      period = $urandom_range(1, 4);
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      send_frame(d, bp, bs);
      // A low stop bit must be followed by a high line so the frame boundary stays defined
      wait_ticks(bs ? OS + $urandom_range(0, 8) : $urandom_range(0, 12));
    end

    wait_ticks(40);
    check("pending_expected_frames", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
